// File: rtl/window_loader.sv
// Raster RGB pixel loader: keeps the two previous image rows in line buffers and
// emits every complete 3x3 neighbourhood as a 216-bit window with a one-cycle strobe.
module window_loader #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pix_valid,
    input  logic [23:0]  pix_data,
    output logic         pix_ready,
    output logic [215:0] pixelData,
    output logic         intensity_enable,
    output logic [15:0]  center_row,
    output logic [15:0]  center_col,
    output logic         busy,
    output logic         frame_done
);
    localparam int DATA_W = 24;
    localparam int COL_W  = 3 * DATA_W;
    localparam int IDX_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [15:0]       row;
    logic [15:0]       col;
    logic [DATA_W-1:0] lb0 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];

    // The two most recent window columns, each packed as {top, middle, bottom}.
    logic [COL_W-1:0]  col_a_p0;
    logic [COL_W-1:0]  col_b_p0;

    logic [COL_W-1:0]  col_new;
    logic [IDX_W-1:0]  col_idx;
    logic              accept;
    logic              last_pix;
    logic              full_window;

    // Rearranges three columns into the row-major window, pixel0 in the top bits.
    function automatic logic [215:0] pack_window(input logic [COL_W-1:0] a,
                                                 input logic [COL_W-1:0] b,
                                                 input logic [COL_W-1:0] n);
        return {a[71:48], b[71:48], n[71:48],
                a[47:24], b[47:24], n[47:24],
                a[23:0],  b[23:0],  n[23:0]};
    endfunction

    assign accept      = (state == S_LOAD) && pix_valid;
    assign col_idx     = col[IDX_W-1:0];
    assign col_new     = {lb1[col_idx], lb0[col_idx], pix_data};
    assign last_pix    = (row == LAST_ROW) && (col == LAST_COL);
    // Columns 0 and 1 of a row would pair with the previous row's tail, so they never emit.
    assign full_window = (row >= 16'd2) && (col >= 16'd2);

    assign pix_ready   = (state == S_LOAD);
    assign busy        = (state == S_LOAD) || (state == S_DONE);
    assign frame_done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            row              <= 16'd0;
            col              <= 16'd0;
            col_a_p0         <= '0;
            col_b_p0         <= '0;
            pixelData        <= '0;
            intensity_enable <= 1'b0;
            center_row       <= 16'd0;
            center_col       <= 16'd0;
            for (int i = 0; i < IMG_WIDTH; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
        end else begin
            intensity_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        row   <= 16'd0;
                        col   <= 16'd0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        lb1[col_idx] <= lb0[col_idx];
                        lb0[col_idx] <= pix_data;
                        col_a_p0     <= col_b_p0;
                        col_b_p0     <= col_new;
                        if (full_window) begin
                            pixelData        <= pack_window(col_a_p0, col_b_p0, col_new);
                            center_row       <= row - 16'd1;
                            center_col       <= col - 16'd1;
                            intensity_enable <= 1'b1;
                        end
                        if (col == LAST_COL) begin
                            col <= 16'd0;
                            row <= row + 16'd1;
                        end else begin
                            col <= col + 16'd1;
                        end
                        if (last_pix) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
